// File: rtl/mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_responder
// Brief    : Line-fill / write-back memory responder with programmable latency
//            and a DEPTH-line backing store.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 128,
    parameter int IDX_W   = 6,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              err,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt
);

    localparam int         c_DEPTH    = 2 ** IDX_W;
    localparam logic [7:0] c_CNT_INIT = 8'(LATENCY - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic              r_op_write;
    logic              r_req_rd;
    logic              r_req_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_cnt;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic [15:0]       r_rd_cnt;
    logic [15:0]       r_wr_cnt;
    logic [DATA_W-1:0] r_store [c_DEPTH];

    logic              w_req;
    logic              w_start;
    logic              w_enter_resp;
    logic              w_txn_write;
    logic [IDX_W-1:0]  w_txn_idx;
    logic [DATA_W-1:0] w_txn_wdata;
    logic              w_busy_mismatch;

    assign w_req   = mem_read | mem_write;
    assign w_start = (r_state == c_IDLE) && w_req;

    // With LATENCY==1 RESP is entered straight from IDLE, so the transaction
    // must come from the live inputs rather than the latched copy.
    assign w_enter_resp = (w_next == c_RESP) && (r_state != c_RESP);
    assign w_txn_write  = (r_state == c_IDLE) ? mem_write : r_op_write;
    assign w_txn_idx    = (r_state == c_IDLE) ? mem_addr[IDX_W-1:0] : r_addr[IDX_W-1:0];
    assign w_txn_wdata  = (r_state == c_IDLE) ? mem_wdata : r_wdata;

    assign w_busy_mismatch = (r_state == c_BUSY) &&
                             ((mem_read != r_req_rd) || (mem_write != r_req_wr) ||
                              (mem_addr != r_addr));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_req) begin
                    w_next = (LATENCY == 1) ? c_RESP : c_BUSY;
                end
            end
            c_BUSY: begin
                if (r_cnt == 8'd1) begin
                    w_next = c_RESP;
                end
            end
            c_RESP:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (r_state == c_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_write <= 1'b0;
            r_req_rd   <= 1'b0;
            r_req_wr   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= 8'd0;
        end else if (w_start) begin
            r_op_write <= mem_write;
            r_req_rd   <= mem_read;
            r_req_wr   <= mem_write;
            r_addr     <= mem_addr;
            r_wdata    <= mem_wdata;
            r_cnt      <= c_CNT_INIT;
        end else if ((r_state == c_BUSY) && (r_cnt != 8'd1)) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((w_start && mem_read && mem_write) || w_busy_mismatch) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_enter_resp && !w_txn_write) begin
            r_rdata <= r_store[w_txn_idx];
        end
    end

    // Writes commit on RESP entry, so a reset during BUSY leaves the store untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_store[i] <= '0;
            end
        end else if (w_enter_resp && w_txn_write) begin
            r_store[w_txn_idx] <= w_txn_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_cnt <= 16'd0;
            r_wr_cnt <= 16'd0;
        end else if (r_state == c_RESP) begin
            if (r_op_write) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end else begin
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
        end
    end

    assign mem_rdata = r_rdata;
    assign err       = r_err;
    assign rd_cnt    = r_rd_cnt;
    assign wr_cnt    = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Scoreboard bench for mem_responder with directed transactions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int IDX_W  = 6;
    localparam int LAT    = 4;

    localparam logic [127:0] c_D2 = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_AA55;
    localparam logic [127:0] c_D3 = 128'hDEAD_BEEF_CAFE_F00D_1122_3344_5566_7788;
    localparam logic [127:0] c_D4 = 128'hA5A5_5A5A_0000_FFFF_1234_8765_ABCD_0001;
    localparam logic [127:0] c_D6 = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              err;
    logic [15:0]       rd_cnt;
    logic [15:0]       wr_cnt;

    typedef struct {
        int           cyc;
        logic [127:0] data;
        bit           chk_data;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   t0;

    mem_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .LATENCY(LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .err      (err),
        .rd_cnt   (rd_cnt),
        .wr_cnt   (wr_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ready: mem_ready=1 with no pending request (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("ready_cycle", 128'(cyc), 128'(e.cyc));
                    if (e.chk_data) chk("rdata", mem_rdata, e.data);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [127:0] wdata, input logic [127:0] exp_data, input bit chk_data);
        exp_t e;
        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wdata;
        e.cyc      = cyc + LAT;
        e.data     = exp_data;
        e.chk_data = chk_data;
        q.push_back(e);
    endtask

    task automatic wait_ready(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: mem_ready not seen within 40 cycles", name);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        fork
            monitor();
        join_none

        // Reset state
        do_reset();
        chk("rst_ready", 128'(mem_ready), 128'(0));
        chk("rst_rdata", mem_rdata, 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_rd_cnt", 128'(rd_cnt), 128'(0));
        chk("rst_wr_cnt", 128'(wr_cnt), 128'(0));

        // T1: read after reset
        issue(1'b1, 1'b0, 28'h000_0005, '0, 128'(0), 1'b1);
        wait_ready("t1");
        go_idle();
        chk("t1_rd_cnt", 128'(rd_cnt), 128'(1));
        chk("t1_wr_cnt", 128'(wr_cnt), 128'(0));

        // T2: write then read same line
        do_reset();
        issue(1'b0, 1'b1, 28'h000_0003, c_D2, '0, 1'b0);
        wait_ready("t2w");
        go_idle();
        issue(1'b1, 1'b0, 28'h000_0003, '0, c_D2, 1'b1);
        wait_ready("t2r");
        go_idle();
        chk("t2_wr_cnt", 128'(wr_cnt), 128'(1));
        chk("t2_rd_cnt", 128'(rd_cnt), 128'(1));
        chk("t2_err", 128'(err), 128'(0));

        // T3: write-back to 0x12 then fetch from aliasing 0x52 with no gap
        do_reset();
        issue(1'b0, 1'b1, 28'h000_0012, c_D3, '0, 1'b0);
        t0 = cyc;
        wait_ready("t3w");
        chk("t3_wb_cycle", 128'(cyc), 128'(t0 + 4));
        issue(1'b1, 1'b0, 28'h000_0052, '0, c_D3, 1'b1);
        wait_ready("t3r");
        chk("t3_fetch_cycle", 128'(cyc), 128'(t0 + 9));
        go_idle();
        chk("t3_err", 128'(err), 128'(0));
        chk("t3_wr_cnt", 128'(wr_cnt), 128'(1));
        chk("t3_rd_cnt", 128'(rd_cnt), 128'(1));

        // T4: read and write together act as a write and raise a sticky error
        do_reset();
        issue(1'b1, 1'b1, 28'h000_0009, c_D4, '0, 1'b0);
        wait_ready("t4w");
        go_idle();
        chk("t4_err", 128'(err), 128'(1));
        chk("t4_wr_cnt", 128'(wr_cnt), 128'(1));
        chk("t4_rd_cnt", 128'(rd_cnt), 128'(0));
        issue(1'b1, 1'b0, 28'h000_0009, '0, c_D4, 1'b1);
        wait_ready("t4r");
        go_idle();
        chk("t4_err_sticky", 128'(err), 128'(1));

        // T5: read dropped in the second BUSY cycle still completes on time
        do_reset();
        issue(1'b1, 1'b0, 28'h000_0020, '0, 128'(0), 1'b1);
        @(negedge clk);
        @(negedge clk);
        mem_read = 1'b0;
        wait_ready("t5");
        go_idle();
        chk("t5_err", 128'(err), 128'(1));
        chk("t5_rd_cnt", 128'(rd_cnt), 128'(1));

        // T6: reset during BUSY of a write drops it entirely
        do_reset();
        @(negedge clk);
        mem_write = 1'b1;
        mem_addr  = 28'h000_0007;
        mem_wdata = c_D6;
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b1;
        mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("t6_wr_cnt", 128'(wr_cnt), 128'(0));
        chk("t6_err", 128'(err), 128'(0));
        issue(1'b1, 1'b0, 28'h000_0007, '0, 128'(0), 1'b1);
        wait_ready("t6r");
        go_idle();
        chk("t6_rd_cnt", 128'(rd_cnt), 128'(1));

        repeat (5) @(negedge clk);
        chk("pending_expected", 128'(q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
